// File: rtl/vga_frame_ctrl_if.sv
// Pattern-select configuration handshake between a host (master) and the
// VGA frame controller (slave).
interface vga_frame_ctrl_if #(
    parameter int SEL_W = 4
) ();
    logic             cfg_valid;
    logic [SEL_W-1:0] cfg_data;
    logic             cfg_ready;

    modport master (output cfg_valid, output cfg_data, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_data, output cfg_ready);
endinterface

// File: rtl/vga_frame_ctrl.sv
// VGA timing sequencer: pixel-rate divider, h/v counters, registered sync/DE/
// coordinate outputs, and a pattern-select register committed at frame boundaries.
module vga_frame_ctrl #(
    parameter int   DIV         = 2,
    parameter int   H_TOTAL     = 800,
    parameter int   H_SYNC      = 96,
    parameter int   H_ACT_START = 144,
    parameter int   H_ACT       = 640,
    parameter int   V_TOTAL     = 525,
    parameter int   V_SYNC      = 2,
    parameter int   V_ACT_START = 35,
    parameter int   V_ACT       = 480,
    parameter logic SYNC_POL    = 1'b1,
    parameter int   SEL_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    vga_frame_ctrl_if.slave  cfg,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [9:0]       o_x,
    output logic [9:0]       o_y,
    output logic             o_pix_tick,
    output logic             o_frame_start,
    output logic [SEL_W-1:0] o_pattern_sel,
    output logic             o_cfg_applied,
    output logic [15:0]      o_frame_cnt
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = 10;

    typedef enum logic {ST_IDLE, ST_PENDING} cfg_state_t;

    logic [DIV_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic [SEL_W-1:0] r_pending;
    cfg_state_t       r_state;

    logic w_tick;
    logic w_h_last;
    logic w_v_last;
    logic w_boundary;
    logic w_h_act;
    logic w_v_act;
    logic w_de;

    assign w_tick     = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_h_last   = (r_h == CNT_W'(H_TOTAL - 1));
    assign w_v_last   = (r_v == CNT_W'(V_TOTAL - 1));
    assign w_boundary = w_tick && w_h_last && w_v_last;
    assign w_h_act    = (r_h >= CNT_W'(H_ACT_START)) && (r_h < CNT_W'(H_ACT_START + H_ACT));
    assign w_v_act    = (r_v >= CNT_W'(V_ACT_START)) && (r_v < CNT_W'(V_ACT_START + V_ACT));
    assign w_de       = w_h_act && w_v_act;

    // Stage p0: pixel divider and raster counters, advancing once per tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_h       <= '0;
            r_v       <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    // Stage p1: timing outputs registered from the current counter values
    always_ff @(posedge clk) begin
        if (reset) begin
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_pix_tick    <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            o_hsync       <= (r_h < CNT_W'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
            o_vsync       <= (r_v < CNT_W'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
            o_de          <= w_de;
            o_x           <= w_de ? r_h - CNT_W'(H_ACT_START) : '0;
            o_y           <= w_de ? r_v - CNT_W'(V_ACT_START) : '0;
            o_pix_tick    <= w_tick;
            o_frame_start <= w_boundary;
            if (w_boundary) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end

    // A word accepted on the boundary clk itself waits for the following boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pending     <= '0;
            cfg.cfg_ready <= 1'b1;
            o_pattern_sel <= '0;
            o_cfg_applied <= 1'b0;
        end else begin
            o_cfg_applied <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg.cfg_valid) begin
                        r_pending     <= cfg.cfg_data;
                        r_state       <= ST_PENDING;
                        cfg.cfg_ready <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (w_boundary) begin
                        o_pattern_sel <= r_pending;
                        o_cfg_applied <= 1'b1;
                        r_state       <= ST_IDLE;
                        cfg.cfg_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench for vga_frame_ctrl using a reduced 20x10 raster (400 clks per frame).
module tb_vga_frame_ctrl;
    localparam int DIV = 2, H_TOTAL = 20, H_SYNC = 3, H_ACT_START = 5, H_ACT = 10;
    localparam int V_TOTAL = 10, V_SYNC = 2, V_ACT_START = 3, V_ACT = 5;

    logic        clk;
    logic        reset;
    logic        hsync, vsync, de, pix_tick, frame_start, cfg_applied;
    logic [9:0]  x, y;
    logic [3:0]  pattern_sel;
    logic [15:0] frame_cnt;

    vga_frame_ctrl_if #(.SEL_W(4)) mif ();

    vga_frame_ctrl #(
        .DIV(DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_ACT_START(H_ACT_START),
        .H_ACT(H_ACT), .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_ACT_START(V_ACT_START),
        .V_ACT(V_ACT), .SYNC_POL(1'b1), .SEL_W(4)
    ) dut (
        .clk(clk), .reset(reset), .cfg(mif),
        .o_hsync(hsync), .o_vsync(vsync), .o_de(de), .o_x(x), .o_y(y),
        .o_pix_tick(pix_tick), .o_frame_start(frame_start),
        .o_pattern_sel(pattern_sel), .o_cfg_applied(cfg_applied), .o_frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] k;
        logic        hs;
        logic        vs;
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        tk;
        logic        fs;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    int n_checks = 0;
    int n_err    = 0;
    int k        = 0;
    int applied_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // k counts clocks since reset release; outputs sampled 1 time unit after each edge
    task automatic step();
        @(posedge clk);
        #1;
        k++;
        if (cfg_applied === 1'b1) applied_cnt++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (5) step();
        chk("rst_hsync", hsync, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_de_xy", {de, x, y}, 0);
        chk("rst_pulses", {pix_tick, frame_start, cfg_applied}, 0);
        chk("rst_ready", mif.cfg_ready, 1);
        chk("rst_sel", pattern_sel, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        reset = 1'b0;
        k = -1;
    endtask

    function automatic vec_t mkv(input int kk, input bit hs, input bit vs, input bit d,
                                 input int xx, input int yy, input bit tk, input bit fs);
        vec_t v;
        v.k = 16'(kk); v.hs = hs; v.vs = vs; v.de = d;
        v.x = 10'(xx); v.y = 10'(yy); v.tk = tk; v.fs = fs;
        return v;
    endfunction

    initial begin
        int ti, tick_n, hs_n, vs_n, de_n, fs_n, fs_k1, fs_k2, xy_bad;

        // sample k reflects raster position T = floor(k/2) = v*20 + h
        tbl[0]  = mkv(0,   1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(1,   1, 1, 0, 0, 0, 1, 0);
        tbl[2]  = mkv(5,   1, 1, 0, 0, 0, 1, 0);
        tbl[3]  = mkv(6,   0, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mkv(78,  0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mkv(80,  1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mkv(129, 0, 0, 0, 0, 0, 1, 0);
        tbl[7]  = mkv(130, 0, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mkv(148, 0, 0, 1, 9, 0, 0, 0);
        tbl[9]  = mkv(150, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mkv(174, 0, 0, 1, 2, 1, 0, 0);
        tbl[11] = mkv(308, 0, 0, 1, 9, 4, 0, 0);
        tbl[12] = mkv(330, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mkv(398, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mkv(399, 0, 0, 0, 0, 0, 1, 1);
        tbl[15] = mkv(400, 1, 1, 0, 0, 0, 0, 0);
        tbl[16] = mkv(530, 0, 0, 1, 0, 0, 0, 0);

        reset = 1'b1;
        mif.cfg_valid = 1'b0;
        mif.cfg_data  = 4'h0;
        apply_reset();

        ti = 0; tick_n = 0; hs_n = 0; vs_n = 0; de_n = 0; fs_n = 0;
        fs_k1 = -1; fs_k2 = -1; xy_bad = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (pix_tick) begin
                tick_n++;
                if (hsync) hs_n++;
                if (vsync) vs_n++;
                if (de) de_n++;
            end
            if (frame_start) begin
                fs_n++;
                if (fs_n == 1) fs_k1 = k; else fs_k2 = k;
            end
            if (!de && (x != 0 || y != 0)) xy_bad++;
            if (ti < NVEC && int'(tbl[ti].k) == k) begin
                chk($sformatf("vec_k%0d", k),
                    {7'd0, hsync, vsync, de, x, y, pix_tick, frame_start},
                    {7'd0, tbl[ti].hs, tbl[ti].vs, tbl[ti].de, tbl[ti].x, tbl[ti].y,
                     tbl[ti].tk, tbl[ti].fs});
                ti++;
            end
        end
        chk("vec_all_hit", ti, NVEC);
        chk("tick_count", tick_n, 400);
        chk("hsync_ticks", hs_n, 60);
        chk("vsync_ticks", vs_n, 80);
        chk("de_ticks", de_n, 100);
        chk("frame_start_count", fs_n, 2);
        chk("frame_start_k1", fs_k1, 399);
        chk("frame_start_k2", fs_k2, 799);
        chk("frame_cnt_2", frame_cnt, 2);
        chk("xy_zero_outside", xy_bad, 0);

        // Mid-frame config, then back-pressured second word
        applied_cnt = 0;
        run_to(1000);
        chk("ready_idle", mif.cfg_ready, 1);
        mif.cfg_valid = 1'b1;
        mif.cfg_data  = 4'h5;
        step();
        chk("ready_drop", mif.cfg_ready, 0);
        mif.cfg_data = 4'hA;
        run_to(1050);
        mif.cfg_valid = 1'b0;
        run_to(1198);
        chk("sel_hold_0", pattern_sel, 0);
        chk("ready_held_low", mif.cfg_ready, 0);
        chk("no_early_apply", applied_cnt, 0);
        step();
        chk("sel_applied_5", pattern_sel, 5);
        chk("applied_pulse_5", {cfg_applied, frame_start, mif.cfg_ready}, 3'b111);
        chk("frame_cnt_3", frame_cnt, 3);
        step();
        chk("applied_one_clk", cfg_applied, 0);

        run_to(1210);
        mif.cfg_valid = 1'b1;
        mif.cfg_data  = 4'hA;
        step();
        mif.cfg_valid = 1'b0;
        chk("ready_drop_A", mif.cfg_ready, 0);
        run_to(1598);
        chk("sel_still_5", pattern_sel, 5);
        step();
        chk("sel_applied_A", pattern_sel, 4'hA);
        chk("applied_pulse_A", cfg_applied, 1);

        // Handshake on the boundary clk itself
        run_to(1998);
        mif.cfg_valid = 1'b1;
        mif.cfg_data  = 4'h3;
        step();
        mif.cfg_valid = 1'b0;
        chk("bnd_frame_start", frame_start, 1);
        chk("bnd_not_applied", {cfg_applied, pattern_sel}, {1'b0, 4'hA});
        chk("bnd_latched", mif.cfg_ready, 0);
        run_to(2398);
        chk("bnd_sel_hold_A", pattern_sel, 4'hA);
        step();
        chk("bnd_applied_next", {cfg_applied, pattern_sel}, {1'b1, 4'h3});

        // Reset mid-frame with a pending word
        run_to(2500);
        mif.cfg_valid = 1'b1;
        mif.cfg_data  = 4'h7;
        step();
        mif.cfg_valid = 1'b0;
        run_to(2576);
        chk("pend7_ready", mif.cfg_ready, 0);
        apply_reset();
        applied_cnt = 0;
        step();
        chk("post_rst_origin", {hsync, vsync, de, pix_tick}, 4'b1100);
        chk("post_rst_cfg", {mif.cfg_ready, pattern_sel}, {1'b1, 4'h0});
        chk("post_rst_frame_cnt", frame_cnt, 0);
        run_to(400);
        chk("post_rst_no_apply", applied_cnt, 0);
        chk("post_rst_sel", pattern_sel, 0);
        chk("post_rst_frame_cnt_1", frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
